eim_da_ctrl: RTL
================

EIM_DA_CTRL -- requirements
Module: eim_da_ctrl

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 16, width of the multiplexed EIM DA bus.
REQ-002 SHALL have parameter ADDR_HI_WIDTH, default 3, number of upper EIM address pins.
REQ-003 SHALL have parameter RD_TIMEOUT, default 64, maximum number of sys_clk cycles to wait for sys_ack on a read.
REQ-004 SHALL have one clock, sys_clk; all logic SHALL be on its rising edge.
REQ-005 SHALL have reset sys_rst, which is synchronous and active-high.
REQ-006 Ports SHALL be as follows:
- sys_clk  in  1  clock.
- sys_rst  in  1  synchronous active-high reset.
- eim_cs_n  in  1  chip select, active low.
- eim_adv_n  in  1  address valid, active low.
- eim_we_n  in  1  write enable, active low.
- eim_oe_n  in  1  output enable, active low.
- eim_a_hi  in  ADDR_HI_WIDTH  upper address pins.
- da_ro  in  BUS_WIDTH  value read from the DA pins (from the IO-buffer receiver output).
- da_di  out  BUS_WIDTH  value to drive onto the DA pins (to the IO-buffer driver input).
- da_t  out  1  IO-buffer tristate control; 1 = pins released.
- eim_wait_n  out  1  wait to host; 0 = read data not ready.
- sys_addr  out  ADDR_HI_WIDTH+BUS_WIDTH  transaction address.
- sys_wr  out  1  write strobe, one-cycle pulse.
- sys_rd  out  1  read strobe, one-cycle pulse.
- sys_wdata  out  2*BUS_WIDTH  write data.
- sys_rdata  in  2*BUS_WIDTH  read data from the system.
- sys_ack  in  1  read data valid.

Function
REQ-007 SHALL register eim_cs_n, eim_adv_n, eim_we_n, eim_oe_n, eim_a_hi and da_ro once; the FSM SHALL act only on these registered copies (the "_r" values).
REQ-008 FSM states SHALL be IDLE, ADDR, WR_LO, WR_HI, RD_REQ, RD_WAIT, RD_LO, RD_HI and WAIT_CS.
REQ-009 IDLE: when cs_r=0 and adv_r=0, SHALL load sys_addr={a_hi_r,da_ro_r} and go to ADDR.
REQ-010 ADDR: when adv_r=1, SHALL go to WR_LO if we_r=0, else to RD_REQ if oe_r=0, else stay in ADDR.
REQ-011 WR_LO: when we_r=0, SHALL load sys_wdata[15:0]=da_ro_r and go to WR_HI.
REQ-012 WR_HI: SHALL load sys_wdata[31:16]=da_ro_r, pulse sys_wr for exactly one cycle starting the next cycle, and go to WAIT_CS; sys_wr SHALL see stable sys_addr/sys_wdata.
REQ-013 RD_REQ: SHALL pulse sys_rd for one cycle, clear the timeout counter, and go to RD_WAIT.
REQ-014 eim_wait_n SHALL be 0 from entry to RD_REQ until read data is latched, and 1 otherwise.
REQ-015 RD_WAIT: on sys_ack=1 SHALL latch sys_rdata and go to RD_LO; otherwise SHALL increment the counter.
REQ-016 If the counter reaches RD_TIMEOUT-1 without ack, SHALL latch 32'hDEADBEEF and go to RD_LO.
REQ-017 If ack and timeout occur in the same cycle, ack SHALL win.
REQ-018 RD_LO SHALL drive da_di=rdata[15:0] for one cycle; RD_HI SHALL drive da_di=rdata[31:16] for one cycle; then SHALL go to WAIT_CS.
REQ-019 da_t SHALL equal 0 only when the state is RD_LO or RD_HI and oe_r=0; da_t is decoded from registered state and signals only.
REQ-020 WAIT_CS: when cs_r=1 SHALL go to IDLE.
REQ-021 cs_r=1 in any state SHALL force IDLE the next cycle with da_t=1.
REQ-022 A transaction aborted by cs_r=1 SHALL issue no sys_wr or sys_rd if the strobe has not already fired.
REQ-023 sys_ack outside RD_WAIT SHALL be ignored, including a late ack for an aborted read.
REQ-024 sys_wr and sys_rd SHALL never be asserted in the same cycle.
REQ-025 da_di SHALL hold its last value while da_t=1.

Reset
REQ-026 When sys_rst=1 at a clock edge: state=IDLE, da_t=1, da_di=0, eim_wait_n=1, sys_wr=0, sys_rd=0, sys_addr=0, sys_wdata=0, counter=0, input registers cleared to idle values (cs_r=adv_r=we_r=oe_r=1).
REQ-027 Reset asserted mid-transaction SHALL abort it with no strobe emitted.

Verification
REQ-028 Write: cs=0, adv=0 with a_hi=3'b101 and da=16'h1234, then we=0 with da=16'hBEEF then 16'hCAFE -> one sys_wr pulse with sys_addr=19'h51234 and sys_wdata=32'hCAFEBEEF.
REQ-029 Read: address 19'h00010, oe=0, sys_ack 5 cycles after sys_rd with sys_rdata=32'h89ABCDEF -> eim_wait_n low until latch, then da_t=0 with da_di=16'hCDEF then 16'h89AB, then da_t=1.
REQ-030 Read with no ack -> eim_wait_n released after 64 cycles and da_di=16'hBEEF then 16'hDEAD.
REQ-031 cs raised during WR_LO -> IDLE, no sys_wr; a subsequent transaction completes normally.
REQ-032 cs raised in RD_WAIT, then ack arrives -> ack ignored, da_t stays 1, eim_wait_n=1.
REQ-033 sys_rst pulsed during RD_LO -> all outputs at reset values the next cycle, da_t=1.

Source files
------------

// File: rtl/eim_da_ctrl.sv
// EIM multiplexed address/data bus slave: turns host bus cycles into single-cycle
// sys_wr/sys_rd strobes and returns 32-bit read data as two 16-bit beats.
module eim_da_ctrl #(
    parameter int BUS_WIDTH     = 16,
    parameter int ADDR_HI_WIDTH = 3,
    parameter int RD_TIMEOUT    = 64
) (
    input  logic                             sys_clk,
    input  logic                             sys_rst,
    input  logic                             eim_cs_n,
    input  logic                             eim_adv_n,
    input  logic                             eim_we_n,
    input  logic                             eim_oe_n,
    input  logic [ADDR_HI_WIDTH-1:0]         eim_a_hi,
    input  logic [BUS_WIDTH-1:0]             da_ro,
    output logic [BUS_WIDTH-1:0]             da_di,
    output logic                             da_t,
    output logic                             eim_wait_n,
    output logic [ADDR_HI_WIDTH+BUS_WIDTH-1:0] sys_addr,
    output logic                             sys_wr,
    output logic                             sys_rd,
    output logic [2*BUS_WIDTH-1:0]           sys_wdata,
    input  logic [2*BUS_WIDTH-1:0]           sys_rdata,
    input  logic                             sys_ack
);

    // state   | meaning
    // IDLE    | waiting for cs and adv low
    // ADDR    | address latched, waiting for adv high and direction
    // WR_LO   | capture low write beat
    // WR_HI   | capture high write beat, strobe sys_wr next cycle
    // RD_REQ  | strobe sys_rd next cycle, clear timeout counter
    // RD_WAIT | waiting for sys_ack or timeout
    // RD_LO   | drive low read beat
    // RD_HI   | drive high read beat
    // WAIT_CS | transaction done, waiting for cs high
    typedef enum logic [3:0] {
        IDLE, ADDR, WR_LO, WR_HI, RD_REQ, RD_WAIT, RD_LO, RD_HI, WAIT_CS
    } state_t;

    localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [2*BUS_WIDTH-1:0] TIMEOUT_DATA = (2*BUS_WIDTH)'(32'hDEADBEEF);

    state_t state, state_nxt;

    logic                     cs_r, adv_r, we_r, oe_r;
    logic [ADDR_HI_WIDTH-1:0] a_hi_r;
    logic [BUS_WIDTH-1:0]     da_ro_r;
    logic [CNT_W-1:0]         cnt;
    logic [2*BUS_WIDTH-1:0]   rdata_q;
    logic                     take_ack, take_timeout;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cs_r    <= 1'b1;
            adv_r   <= 1'b1;
            we_r    <= 1'b1;
            oe_r    <= 1'b1;
            a_hi_r  <= '0;
            da_ro_r <= '0;
        end else begin
            cs_r    <= eim_cs_n;
            adv_r   <= eim_adv_n;
            we_r    <= eim_we_n;
            oe_r    <= eim_oe_n;
            a_hi_r  <= eim_a_hi;
            da_ro_r <= da_ro;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // Deasserted chip select overrides everything, so acks are only seen mid-read.
    always_comb begin
        state_nxt    = state;
        take_ack     = 1'b0;
        take_timeout = 1'b0;
        if (cs_r) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (!adv_r) state_nxt = ADDR;
                ADDR: begin
                    if (adv_r) begin
                        if (!we_r)      state_nxt = WR_LO;
                        else if (!oe_r) state_nxt = RD_REQ;
                    end
                end
                WR_LO:   if (!we_r) state_nxt = WR_HI;
                WR_HI:   state_nxt = WAIT_CS;
                RD_REQ:  state_nxt = RD_WAIT;
                RD_WAIT: begin
                    if (sys_ack) begin
                        take_ack  = 1'b1;
                        state_nxt = RD_LO;
                    end else if (cnt == CNT_LAST) begin
                        take_timeout = 1'b1;
                        state_nxt    = RD_LO;
                    end
                end
                RD_LO:   state_nxt = RD_HI;
                RD_HI:   state_nxt = WAIT_CS;
                WAIT_CS: state_nxt = WAIT_CS;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sys_addr  <= '0;
            sys_wdata <= '0;
            sys_wr    <= 1'b0;
            sys_rd    <= 1'b0;
            cnt       <= '0;
            rdata_q   <= '0;
            da_di     <= '0;
        end else begin
            sys_wr <= (state == WR_HI)  && !cs_r;
            sys_rd <= (state == RD_REQ) && !cs_r;
            if (state == IDLE && state_nxt == ADDR)
                sys_addr <= {a_hi_r, da_ro_r};
            if (state == WR_LO && state_nxt == WR_HI)
                sys_wdata[BUS_WIDTH-1:0] <= da_ro_r;
            if (state == WR_HI && state_nxt == WAIT_CS)
                sys_wdata[2*BUS_WIDTH-1:BUS_WIDTH] <= da_ro_r;
            if (state == RD_REQ)
                cnt <= '0;
            else if (state == RD_WAIT && state_nxt == RD_WAIT)
                cnt <= cnt + CNT_W'(1);
            // da_di is loaded one edge ahead so each beat appears with its state.
            if (take_ack) begin
                rdata_q <= sys_rdata;
                da_di   <= sys_rdata[BUS_WIDTH-1:0];
            end else if (take_timeout) begin
                rdata_q <= TIMEOUT_DATA;
                da_di   <= TIMEOUT_DATA[BUS_WIDTH-1:0];
            end else if (state == RD_LO && state_nxt == RD_HI) begin
                da_di <= rdata_q[2*BUS_WIDTH-1:BUS_WIDTH];
            end
        end
    end

    assign da_t       = !(((state == RD_LO) || (state == RD_HI)) && !oe_r);
    assign eim_wait_n = !((state == RD_REQ) || (state == RD_WAIT));

endmodule
